// File: rtl/lsd_pkg.sv
// Shared types and helpers for the LSD lane selector: FSM states, segment class
// codes, a generic segment container and a ceiling-log2 helper.
package lsd_pkg;

  function automatic int log2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_LEFT, CLS_RIGHT} cls_t;

  localparam int SEG_W = 16;
  typedef struct packed {
    logic [SEG_W-1:0] start_v;
    logic [SEG_W-1:0] start_h;
    logic [SEG_W-1:0] end_v;
    logic [SEG_W-1:0] end_h;
  } seg_t;

endpackage

// File: rtl/lsd_seg_classifier.sv
// Stage 2: squared segment length and left/right/none classification.
// Define LSD_LANE_SIDE_CHECK_EN to also require the segment midpoint on the matching half.
module lsd_seg_classifier import lsd_pkg::*; #(
  parameter int V_BITW      = 9,
  parameter int H_BITW      = 10,
  parameter int IMAGE_WIDTH = 640,
  parameter int MIN_LEN_SQ  = 400,
  localparam int L_W = 2 * ((H_BITW > V_BITW) ? H_BITW : V_BITW) + 1
) (
  input  logic signed [V_BITW:0] dv,
  input  logic signed [H_BITW:0] dh,
  input  logic        [H_BITW:0] mid2,
  output logic        [L_W-1:0]  len2,
  output cls_t                   cls
);

`ifdef LSD_LANE_SIDE_CHECK_EN
  localparam bit SIDE_CHK = 1'b1;
`else
  localparam bit SIDE_CHK = 1'b0;
`endif

  // mid2 is twice the midpoint column, so compare against the full width
  localparam logic [H_BITW:0] CENTRE2 = (H_BITW+1)'(IMAGE_WIDTH);
  localparam logic [L_W-1:0]  MIN_L   = L_W'(MIN_LEN_SQ);

  logic [V_BITW:0] av;
  logic [H_BITW:0] ah;
  logic            on_left;

  assign av      = dv[V_BITW] ? -dv : dv;
  assign ah      = dh[H_BITW] ? -dh : dh;
  assign len2    = L_W'(av) * L_W'(av) + L_W'(ah) * L_W'(ah);
  assign on_left = mid2 < CENTRE2;

  always_comb begin
    cls = CLS_NONE;
    if (dv != 0 && dh != 0 && len2 >= MIN_L) begin
      if (dv[V_BITW] != dh[H_BITW]) begin
        if (!SIDE_CHK || on_left) cls = CLS_LEFT;
      end else begin
        if (!SIDE_CHK || !on_left) cls = CLS_RIGHT;
      end
    end
  end

endmodule

// File: rtl/lsd_lane_selector.sv
// Scans the LSD segment buffer on each in_ready rising edge and reports the longest
// left and right lane candidates with a one-cycle out_valid strobe.
module lsd_lane_selector import lsd_pkg::*; #(
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int IMAGE_WIDTH  = 640,
  parameter int RAM_SIZE     = 4096,
  parameter int MIN_LEN_SQ   = 400,
  localparam int V_BITW    = log2(FRAME_HEIGHT),
  localparam int H_BITW    = log2(FRAME_WIDTH),
  localparam int ADDR_BITW = log2(RAM_SIZE)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_ready,
  input  logic [ADDR_BITW:0]   in_line_num,
  output logic [ADDR_BITW-1:0] out_rd_addr,
  input  logic [V_BITW-1:0]    in_start_v,
  input  logic [H_BITW-1:0]    in_start_h,
  input  logic [V_BITW-1:0]    in_end_v,
  input  logic [H_BITW-1:0]    in_end_h,
  output logic                 out_busy,
  output logic                 out_valid,
  output logic                 out_left_found,
  output logic                 out_right_found,
  output logic [V_BITW-1:0]    out_left_start_v,
  output logic [H_BITW-1:0]    out_left_start_h,
  output logic [V_BITW-1:0]    out_left_end_v,
  output logic [H_BITW-1:0]    out_left_end_h,
  output logic [V_BITW-1:0]    out_right_start_v,
  output logic [H_BITW-1:0]    out_right_start_h,
  output logic [V_BITW-1:0]    out_right_end_v,
  output logic [H_BITW-1:0]    out_right_end_h
);

  localparam int L_W = 2 * ((H_BITW > V_BITW) ? H_BITW : V_BITW) + 1;

  typedef struct packed {
    logic [V_BITW-1:0] start_v;
    logic [H_BITW-1:0] start_h;
    logic [V_BITW-1:0] end_v;
    logic [H_BITW-1:0] end_h;
  } lseg_t;

  state_t                 state;
  logic                   ready_q, drain_q, start, last_addr;
  logic [ADDR_BITW:0]     num_q;
  logic [ADDR_BITW-1:0]   addr_q;
  logic                   s1_vld;
  lseg_t                  s1_seg;
  logic signed [V_BITW:0] s1_dv;
  logic signed [H_BITW:0] s1_dh;
  logic [H_BITW:0]        s1_mid2;
  logic [L_W-1:0]         len2, l_len, r_len;
  cls_t                   cls;
  lseg_t                  l_best, r_best, l_out, r_out;
  logic                   l_hit, r_hit;

  assign start     = (state == ST_IDLE) && in_ready && !ready_q;
  assign last_addr = ({1'b0, addr_q} + (ADDR_BITW+1)'(1)) == num_q;
  assign out_busy  = (state == ST_SCAN) || (state == ST_DRAIN);
  assign out_rd_addr = addr_q;

  assign {out_left_start_v,  out_left_start_h,  out_left_end_v,  out_left_end_h}  = l_out;
  assign {out_right_start_v, out_right_start_h, out_right_end_v, out_right_end_h} = r_out;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ready_q         <= 1'b0;
      drain_q         <= 1'b0;
      num_q           <= '0;
      addr_q          <= '0;
      out_valid       <= 1'b0;
      out_left_found  <= 1'b0;
      out_right_found <= 1'b0;
      l_out           <= '0;
      r_out           <= '0;
    end else begin
      ready_q   <= in_ready;
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          addr_q  <= '0;
          num_q   <= in_line_num;
          drain_q <= 1'b0;
          if (in_line_num == '0) begin
            state           <= ST_DONE;
            out_valid       <= 1'b1;
            out_left_found  <= 1'b0;
            out_right_found <= 1'b0;
            l_out           <= '0;
            r_out           <= '0;
          end else begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!in_ready)      state <= ST_IDLE;
          else if (last_addr) state <= ST_DRAIN;
          else                addr_q <= addr_q + ADDR_BITW'(1);
        end
        // two cycles let the last segment clear both pipeline stages
        ST_DRAIN: begin
          if (!in_ready) begin
            state <= ST_IDLE;
          end else if (drain_q) begin
            state           <= ST_DONE;
            out_valid       <= 1'b1;
            out_left_found  <= l_hit;
            out_right_found <= r_hit;
            l_out           <= l_best;
            r_out           <= r_best;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lsd_seg_classifier #(
    .V_BITW(V_BITW), .H_BITW(H_BITW), .IMAGE_WIDTH(IMAGE_WIDTH), .MIN_LEN_SQ(MIN_LEN_SQ)
  ) u_cls (
    .dv(s1_dv), .dh(s1_dh), .mid2(s1_mid2), .len2(len2), .cls(cls)
  );

  // strict '>' keeps the lower address on equal lengths; a frame start overrides stale updates
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_seg  <= '0;
      s1_dv   <= '0;
      s1_dh   <= '0;
      s1_mid2 <= '0;
      l_best  <= '0;
      r_best  <= '0;
      l_len   <= '0;
      r_len   <= '0;
      l_hit   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      s1_vld  <= (state == ST_SCAN);
      s1_seg  <= {in_start_v, in_start_h, in_end_v, in_end_h};
      s1_dv   <= $signed({1'b0, in_end_v}) - $signed({1'b0, in_start_v});
      s1_dh   <= $signed({1'b0, in_end_h}) - $signed({1'b0, in_start_h});
      s1_mid2 <= {1'b0, in_start_h} + {1'b0, in_end_h};
      if (start) begin
        l_best <= '0;
        r_best <= '0;
        l_len  <= '0;
        r_len  <= '0;
        l_hit  <= 1'b0;
        r_hit  <= 1'b0;
      end else if (s1_vld) begin
        if (cls == CLS_LEFT && len2 > l_len) begin
          l_best <= s1_seg;
          l_len  <= len2;
          l_hit  <= 1'b1;
        end
        if (cls == CLS_RIGHT && len2 > r_len) begin
          r_best <= s1_seg;
          r_len  <= len2;
          r_hit  <= 1'b1;
        end
      end
    end
  end

endmodule
